// File: rtl/convolutional_encoder.sv
// K=7 convolutional encoder (g0=133, g1=171 octal) with 1/2, 2/3 and 3/4 puncturing.
// Serial bits in with valid/ready; punctured coded bits out serially with valid only.
module convolutional_encoder #(
  parameter int unsigned RATE_WIDTH = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [RATE_WIDTH-1:0] Rate,
  input  logic                  InValid,
  input  logic                  Input,
  output logic                  InReady,
  output logic                  OutValid,
  output logic                  Output
);

  localparam logic [RATE_WIDTH-1:0] RateHalf         = RATE_WIDTH'(0);
  localparam logic [RATE_WIDTH-1:0] RateTwoThirds    = RATE_WIDTH'(1);
  localparam logic [RATE_WIDTH-1:0] RateThreeQuarter = RATE_WIDTH'(2);

  logic [5:0]            r_shift;
  logic [1:0]            r_phase;
  logic [RATE_WIDTH-1:0] r_rate;
  logic                  r_pending;
  logic                  r_pend_bit;
  logic                  r_out_valid;
  logic                  r_out;

  logic [5:0]            w_shift_d;
  logic [1:0]            w_phase_d;
  logic [RATE_WIDTH-1:0] w_rate_d;
  logic                  w_pending_d;
  logic                  w_pend_bit_d;
  logic                  w_out_valid_d;
  logic                  w_out_d;

  logic                  w_accept;
  logic                  w_a;
  logic                  w_b;
  logic                  w_emit_a;
  logic                  w_emit_b;
  logic [1:0]            w_last_phase;
  logic [RATE_WIDTH-1:0] w_rate_sel;

  assign InReady  = !r_pending && !Start;
  assign OutValid = r_out_valid;
  assign Output   = r_out;

  assign w_accept = InValid && InReady;

  // r_shift[i] holds x(i+1); the incoming bit is x0.
  assign w_a = Input ^ r_shift[1] ^ r_shift[2] ^ r_shift[4] ^ r_shift[5];
  assign w_b = Input ^ r_shift[0] ^ r_shift[1] ^ r_shift[2] ^ r_shift[5];

  // Phase 1 keeps only A (2/3 and 3/4); phase 2 keeps only B (3/4 only).
  assign w_emit_a = !((r_rate == RateThreeQuarter) && (r_phase == 2'd2));
  assign w_emit_b = (r_phase != 2'd1);

  // Unsupported rate codes fall back to 1/2.
  assign w_rate_sel = ((Rate == RateTwoThirds) || (Rate == RateThreeQuarter)) ? Rate : RateHalf;

  always_comb begin
    w_last_phase = 2'd0;
    if (r_rate == RateTwoThirds) begin
      w_last_phase = 2'd1;
    end else if (r_rate == RateThreeQuarter) begin
      w_last_phase = 2'd2;
    end
  end

  always_comb begin
    w_shift_d     = r_shift;
    w_phase_d     = r_phase;
    w_rate_d      = r_rate;
    w_pending_d   = r_pending;
    w_pend_bit_d  = r_pend_bit;
    w_out_valid_d = 1'b0;
    w_out_d       = 1'b0;

    if (Start) begin
      w_shift_d   = '0;
      w_phase_d   = 2'd0;
      w_pending_d = 1'b0;
      w_rate_d    = w_rate_sel;
    end else if (w_accept) begin
      w_shift_d     = {r_shift[4:0], Input};
      w_phase_d     = (r_phase == w_last_phase) ? 2'd0 : r_phase + 2'd1;
      w_out_valid_d = 1'b1;
      w_out_d       = w_emit_a ? w_a : w_b;
      w_pending_d   = w_emit_a && w_emit_b;
      w_pend_bit_d  = w_b;
    end else if (r_pending) begin
      w_out_valid_d = 1'b1;
      w_out_d       = r_pend_bit;
      w_pending_d   = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_shift     <= '0;
      r_phase     <= 2'd0;
      r_rate      <= RateHalf;
      r_pending   <= 1'b0;
      r_pend_bit  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= 1'b0;
    end else begin
      r_shift     <= w_shift_d;
      r_phase     <= w_phase_d;
      r_rate      <= w_rate_d;
      r_pending   <= w_pending_d;
      r_pend_bit  <= w_pend_bit_d;
      r_out_valid <= w_out_valid_d;
      r_out       <= w_out_d;
    end
  end

endmodule
